// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit lab CPU controller: data width,
// opcode values and FSM state encoding.
package cpu_pkg;

  localparam int DATA_W = 8;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_LD  = 4'h2;
  localparam logic [3:0] OP_ST  = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8;
  localparam logic [3:0] OP_SHL = 4'h9;
  localparam logic [3:0] OP_SHR = 4'hA;
  localparam logic [3:0] OP_JMP = 4'hB;
  localparam logic [3:0] OP_JZ  = 4'hC;
  localparam logic [3:0] OP_JNZ = 4'hD;
  localparam logic [3:0] OP_LDH = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_TARGET = 3'd3,
    S_HALT   = 3'd4
  } state_t;

endpackage

// File: rtl/cpu_alu.sv
// Combinational accumulator ALU. Produces the new accumulator value and
// whether the current opcode writes the accumulator (and thus the z flag).
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] rf_out,
  input  logic [3:0]        imm4,
  output logic [DATA_W-1:0] result,
  output logic              wr_acc
);

  // Opcode decode; non-accumulator opcodes pass acc through untouched
  always_comb begin
    result = acc;
    wr_acc = 1'b0;
    case (op)
      OP_LDI: begin result = {4'h0, imm4};          wr_acc = 1'b1; end
      OP_LD:  begin result = rf_out;                wr_acc = 1'b1; end
      OP_ADD: begin result = acc + rf_out;          wr_acc = 1'b1; end
      OP_SUB: begin result = acc - rf_out;          wr_acc = 1'b1; end
      OP_AND: begin result = acc & rf_out;          wr_acc = 1'b1; end
      OP_OR:  begin result = acc | rf_out;          wr_acc = 1'b1; end
      OP_XOR: begin result = acc ^ rf_out;          wr_acc = 1'b1; end
      OP_SHL: begin result = {acc[6:0], 1'b0};      wr_acc = 1'b1; end
      OP_SHR: begin result = {1'b0, acc[7:1]};      wr_acc = 1'b1; end
      OP_LDH: begin result = {imm4, acc[3:0]};      wr_acc = 1'b1; end
      default: begin result = acc;                  wr_acc = 1'b0; end
    endcase
  end

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle controller for the 8-bit lab CPU: fetch/decode/execute FSM,
// program counter, instruction register, accumulator and zero flag.
// Optional single-step input enabled by defining CPU_CTRL_STEP_EN.
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter int PC_W = 8
)(
  input  logic              clk,
  input  logic              rst_n,
`ifdef CPU_CTRL_STEP_EN
  input  logic              step,
`endif
  output logic [PC_W-1:0]   pc,
  input  logic [DATA_W-1:0] instr,
  output logic [1:0]        rf_a,
  output logic              rf_ce,
  output logic [DATA_W-1:0] rf_in,
  input  logic [DATA_W-1:0] rf_out,
  output logic [DATA_W-1:0] acc,
  output logic              z,
  output logic              halted
);

  localparam logic [PC_W-1:0] PC_ONE = 1;

  state_t            r_state;
  state_t            w_state_next;
  logic [PC_W-1:0]   r_pc;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_acc;
  logic              r_z;
  logic              w_rf_ce;
  logic              w_go;
  logic              w_taken;
  logic [3:0]        w_op;
  logic [DATA_W-1:0] w_result;
  logic              w_wr_acc;

  assign w_op = r_ir[7:4];

`ifdef CPU_CTRL_STEP_EN
  assign w_go = step;
`else
  assign w_go = 1'b1;
`endif

  // Branch condition uses z as left by the previous instruction
  assign w_taken = (w_op == OP_JMP) ||
                   ((w_op == OP_JZ)  &&  r_z) ||
                   ((w_op == OP_JNZ) && !r_z);

  cpu_alu u_alu (
    .op     (w_op),
    .acc    (r_acc),
    .rf_out (rf_out),
    .imm4   (r_ir[3:0]),
    .result (w_result),
    .wr_acc (w_wr_acc)
  );

  // Next-state and register-file write strobe
  always_comb begin
    w_state_next = r_state;
    w_rf_ce      = 1'b0;
    case (r_state)
      S_FETCH:  if (w_go) w_state_next = S_DECODE;
      S_DECODE: w_state_next = S_EXEC;
      S_EXEC: begin
        w_rf_ce = (w_op == OP_ST);
        if (w_op == OP_JMP || w_op == OP_JZ || w_op == OP_JNZ)
          w_state_next = S_TARGET;
        else if (w_op == OP_HLT)
          w_state_next = S_HALT;
        else
          w_state_next = S_FETCH;
      end
      S_TARGET: w_state_next = S_FETCH;
      S_HALT:   w_state_next = S_HALT;
      default:  w_state_next = S_FETCH;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_state_next;
  end

  // Datapath registers: pc, ir, acc and z
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc  <= '0;
      r_ir  <= '0;
      r_acc <= '0;
      r_z   <= 1'b1;
    end else begin
      case (r_state)
        S_DECODE: begin
          r_ir <= instr;
          r_pc <= r_pc + PC_ONE;
        end
        S_EXEC: begin
          if (w_wr_acc) begin
            r_acc <= w_result;
            r_z   <= (w_result == '0);
          end
        end
        S_TARGET: begin
          // ROM is presenting the operand byte (absolute target) here
          if (w_taken) r_pc <= instr[PC_W-1:0];
          else         r_pc <= r_pc + PC_ONE;
        end
        default: ;
      endcase
    end
  end

  assign pc     = r_pc;
  assign rf_a   = r_ir[1:0];
  assign rf_ce  = w_rf_ce;
  assign rf_in  = r_acc;
  assign acc    = r_acc;
  assign z      = r_z;
  assign halted = (r_state == S_HALT);

endmodule

// File: tb/tb_cpu_ctrl.sv
// Self-checking bench for cpu_ctrl: behavioural ROM (registered read) and
// 3-entry register file with user input at address 3.
module tb_cpu_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] pc, instr, rf_in, rf_out, acc;
  logic [1:0] rf_a;
  logic       rf_ce, z, halted;
`ifdef CPU_CTRL_STEP_EN
  logic       step;
`endif

  logic [7:0] rom [256];
  logic [7:0] rf [4];
  logic [7:0] rf_init [3];
  logic [7:0] user_in;
  logic       tb_load;
  int         wr_count;
  logic [1:0] last_wa;
  logic [7:0] last_wd;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cpu_ctrl dut (
    .clk    (clk),
    .rst_n  (rst_n),
`ifdef CPU_CTRL_STEP_EN
    .step   (step),
`endif
    .pc     (pc),
    .instr  (instr),
    .rf_a   (rf_a),
    .rf_ce  (rf_ce),
    .rf_in  (rf_in),
    .rf_out (rf_out),
    .acc    (acc),
    .z      (z),
    .halted (halted)
  );

  // Synchronous program ROM
  always @(posedge clk) instr <= rom[pc];

  // Register file model; address 3 reads user input and ignores writes
  always @(posedge clk) begin
    if (tb_load) begin
      rf[0] <= rf_init[0];
      rf[1] <= rf_init[1];
      rf[2] <= rf_init[2];
      rf[3] <= 8'h00;
      wr_count <= 0;
    end else if (rf_ce) begin
      if (rf_a != 2'd3) rf[rf_a] <= rf_in;
      wr_count <= wr_count + 1;
      last_wa  <= rf_a;
      last_wd  <= rf_in;
    end
  end

  assign rf_out = (rf_a == 2'd3) ? user_in : rf[rf_a];

  typedef struct {
    logic [7:0] acc0;
    logic [7:0] ins;
    logic [7:0] rv;
    logic [7:0] uin;
    logic [7:0] eacc;
    logic       ez;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 8'hF0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reset for two cycles, reload register file, release on a negedge
  task automatic start();
    @(negedge clk);
    rst_n = 1'b0;
    tb_load = 1'b1;
    tick(2);
    tb_load = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    int bad;
    int c;
    logic [7:0] alu_exp [6];
    logic [7:0] br_ldi [4];
    logic [7:0] br_op  [4];
    logic [7:0] br_pc  [4];

    rst_n = 1'b0;
    tb_load = 1'b1;
    user_in = 8'h00;
    last_wa = 2'd0;
    last_wd = 8'h00;
`ifdef CPU_CTRL_STEP_EN
    step = 1'b1;
`endif
    rf_init[0] = 8'h00; rf_init[1] = 8'h00; rf_init[2] = 8'h00;

    //            acc0   ins    rv     uin    eacc   ez
    vecs[0]  = '{8'h0F, 8'h41, 8'hF5, 8'h00, 8'h04, 1'b0};
    vecs[1]  = '{8'h10, 8'h51, 8'h20, 8'h00, 8'hF0, 1'b0};
    vecs[2]  = '{8'hF0, 8'h61, 8'h0F, 8'h00, 8'h00, 1'b1};
    vecs[3]  = '{8'hA0, 8'h71, 8'h05, 8'h00, 8'hA5, 1'b0};
    vecs[4]  = '{8'hFF, 8'h81, 8'hFF, 8'h00, 8'h00, 1'b1};
    vecs[5]  = '{8'h81, 8'h90, 8'h00, 8'h00, 8'h02, 1'b0};
    vecs[6]  = '{8'h80, 8'h90, 8'h00, 8'h00, 8'h00, 1'b1};
    vecs[7]  = '{8'h01, 8'hA0, 8'h00, 8'h00, 8'h00, 1'b1};
    vecs[8]  = '{8'h82, 8'hA0, 8'h00, 8'h00, 8'h41, 1'b0};
    vecs[9]  = '{8'h33, 8'h10, 8'h00, 8'h00, 8'h00, 1'b1};
    vecs[10] = '{8'h33, 8'hEC, 8'h00, 8'h00, 8'hC3, 1'b0};
    vecs[11] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1};
    vecs[12] = '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h5A, 1'b0};
    vecs[13] = '{8'h00, 8'h31, 8'h77, 8'h00, 8'h00, 1'b1};
    vecs[14] = '{8'h55, 8'h23, 8'h00, 8'h00, 8'h00, 1'b1};
    vecs[15] = '{8'h00, 8'h22, 8'h7E, 8'h00, 8'h7E, 1'b0};
    vecs[16] = '{8'h08, 8'h53, 8'h00, 8'h09, 8'hFF, 1'b0};

    // Reset aborts an ST in progress without writing
    clear_rom();
    rom[0] = 8'h15; rom[1] = 8'h30;
    rf_init[0] = 8'h99;
    start();
    c = 0;
    while (c < 20 && rf_ce !== 1'b1) begin tick(1); c++; end
    chk("st_reached", rf_ce, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_rf_ce_drop", rf_ce, 1'b0);
    tick(2);
    chk("rst_no_write", wr_count, 0);
    chk("rst_r0_kept", rf[0], 8'h99);
    chk("rst_pc", pc, 8'h00);
    chk("rst_acc", acc, 8'h00);
    chk("rst_z", z, 1'b1);
    chk("rst_halted", halted, 1'b0);
    rst_n = 1'b1;
    tick(1);
    chk("rst_fetch_pc0", pc, 8'h00);
    $display("reset-abort: writes=%0d r0=%h pc=%h acc=%h z=%b", wr_count, rf[0], pc, acc, z);

    // Single-instruction vectors: LDI lo; LDH hi; <ins>; HLT
    for (int i = 0; i < 17; i++) begin
      clear_rom();
      rom[0] = {4'h1, vecs[i].acc0[3:0]};
      rom[1] = {4'hE, vecs[i].acc0[7:4]};
      rom[2] = vecs[i].ins;
      rf_init[0] = vecs[i].rv; rf_init[1] = vecs[i].rv; rf_init[2] = vecs[i].rv;
      user_in = vecs[i].uin;
      start();
      c = 0;
      while (c < 40 && halted !== 1'b1) begin tick(1); c++; end
      chk($sformatf("vec%0d_halt", i), halted, 1'b1);
      chk($sformatf("vec%0d_acc", i), acc, vecs[i].eacc);
      chk($sformatf("vec%0d_z", i), z, vecs[i].ez);
      $display("vec %0d acc0=%h instr=%h -> acc=%h z=%b", i, vecs[i].acc0, vecs[i].ins, acc, z);
    end

    // ALU program with 3-cycle instruction latency
    clear_rom();
    rom[0] = 8'h15; rom[1] = 8'h30; rom[2] = 8'h13;
    rom[3] = 8'h40; rom[4] = 8'h50; rom[5] = 8'h50;
    rf_init[0] = 8'h00; rf_init[1] = 8'h00; rf_init[2] = 8'h00;
    user_in = 8'h00;
    alu_exp[0] = 8'h05; alu_exp[1] = 8'h05; alu_exp[2] = 8'h03;
    alu_exp[3] = 8'h08; alu_exp[4] = 8'h03; alu_exp[5] = 8'hFE;
    start();
    for (int i = 0; i < 6; i++) begin
      tick(3);
      chk($sformatf("alu%0d_acc", i), acc, alu_exp[i]);
      chk($sformatf("alu%0d_z", i), z, 1'b0);
      $display("alu step %0d acc=%h z=%b", i, acc, z);
    end
    chk("alu_writes", wr_count, 1);
    chk("alu_wr_addr", last_wa, 2'd0);
    chk("alu_wr_data", last_wd, 8'h05);

    // User input through address 3
    clear_rom();
    rom[0] = 8'h23; rom[1] = 8'h83; rom[2] = 8'h33;
    rf_init[0] = 8'h11; rf_init[1] = 8'h22; rf_init[2] = 8'h33;
    user_in = 8'hA5;
    start();
    tick(3);
    chk("usr_ld_acc", acc, 8'hA5);
    tick(3);
    chk("usr_xor_acc", acc, 8'h00);
    chk("usr_xor_z", z, 1'b1);
    tick(3);
    chk("usr_st_count", wr_count, 1);
    chk("usr_st_addr", last_wa, 2'd3);
    chk("usr_regs", {rf[0], rf[1], rf[2]}, 24'h112233);
    $display("user-input acc=%h z=%b regs=%h %h %h", acc, z, rf[0], rf[1], rf[2]);

    // Conditional branches: JZ/JNZ taken and not taken
    br_ldi[0] = 8'h10; br_op[0] = 8'hC0; br_pc[0] = 8'h10;
    br_ldi[1] = 8'h11; br_op[1] = 8'hC0; br_pc[1] = 8'h03;
    br_ldi[2] = 8'h11; br_op[2] = 8'hD0; br_pc[2] = 8'h10;
    br_ldi[3] = 8'h10; br_op[3] = 8'hD0; br_pc[3] = 8'h03;
    for (int i = 0; i < 4; i++) begin
      clear_rom();
      rom[0] = br_ldi[i]; rom[1] = br_op[i]; rom[2] = 8'h10;
      start();
      tick(6);
      chk($sformatf("br%0d_target_pc", i), pc, 8'h02);
      tick(1);
      chk($sformatf("br%0d_pc", i), pc, br_pc[i]);
      $display("branch %0d op=%h -> pc=%h", i, br_op[i], pc);
    end

    // pc wrap after a 1-byte instruction at the top address
    clear_rom();
    rom[0] = 8'hB0; rom[1] = 8'hFF; rom[8'hFF] = 8'h17;
    start();
    tick(4);
    chk("wrap_jmp_pc", pc, 8'hFF);
    tick(3);
    chk("wrap_pc", pc, 8'h00);
    chk("wrap_acc", acc, 8'h07);
    $display("wrap pc=%h acc=%h", pc, acc);

    // JMP at 0xFE with operand at 0xFF, then HLT holds
    clear_rom();
    rom[0] = 8'hB0; rom[1] = 8'hFE;
    rom[8'hFE] = 8'hB0; rom[8'hFF] = 8'h40; rom[8'h40] = 8'hF0;
    start();
    tick(8);
    chk("topjmp_pc", pc, 8'h40);
    tick(3);
    chk("hlt_halted", halted, 1'b1);
    chk("hlt_pc", pc, 8'h41);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (pc !== 8'h41 || rf_ce !== 1'b0 || halted !== 1'b1) bad++;
    end
    chk("hlt_hold_errs", bad, 0);
    chk("hlt_writes", wr_count, 0);
    $display("halt pc=%h halted=%b writes=%0d", pc, halted, wr_count);

`ifdef CPU_CTRL_STEP_EN
    // Single-step: one instruction per step pulse
    clear_rom();
    rom[0] = 8'h11; rom[1] = 8'h12;
    step = 1'b0;
    start();
    tick(10);
    chk("step_hold_pc", pc, 8'h00);
    chk("step_hold_acc", acc, 8'h00);
    step = 1'b1;
    tick(1);
    step = 1'b0;
    tick(10);
    chk("step1_pc", pc, 8'h01);
    chk("step1_acc", acc, 8'h01);
    step = 1'b1;
    tick(1);
    step = 1'b0;
    tick(10);
    chk("step2_pc", pc, 8'h02);
    chk("step2_acc", acc, 8'h02);
    $display("step pc=%h acc=%h", pc, acc);
    step = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
